dff_pipe: RTL and testbench



---
 rtl/dff_pipe_pkg.sv | 13 +
 rtl/dff_pipe_stage.sv | 46 ++++
 rtl/dff_pipe.sv | 54 +++++
 tb/tb_dff_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared sizing helpers and constants for the dff_pipe elastic pipeline.
package dff_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int STG_IN    = 0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int x = n - 1; x > 0; x = x >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
  localparam int OCC_W = clog2(DEF_DEPTH + 1);
endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one valid+data register of the elastic pipeline.
// Data reset only when DFF_PIPE_DATA_RST_EN is defined.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic             i_rdy_dn,
  output logic             o_rdy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_v;
  logic [WIDTH-1:0] r_d;
  logic             w_rdy;
  logic             w_load;
  // An empty stage is always ready, which lets bubbles collapse under stall.
  assign w_rdy   = !r_v || i_rdy_dn;
  assign w_load  = w_rdy && i_up_valid && !flush;
  assign o_rdy   = w_rdy;
  assign o_valid = r_v;
  assign o_data  = r_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_v <= 1'b0;
    else if (flush) r_v <= 1'b0;
    else if (w_rdy) r_v <= i_up_valid;
  end
`ifdef DFF_PIPE_DATA_RST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_d <= RESET_VAL;
    else if (w_load) r_d <= i_up_data;
  end
`else
  logic w_unused_rst;
  assign w_unused_rst = ^RESET_VAL;
  always_ff @(posedge clk) begin
    if (w_load) r_d <= i_up_data;
  end
`endif
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage elastic register pipeline with back-pressure, flush and occupancy.
// Define DFF_PIPE_DATA_RST_EN to reset data registers to RESET_VAL.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [clog2(DEPTH+1)-1:0]  occupancy
);
  localparam int OW = clog2(DEPTH + 1);
  logic             w_vc  [DEPTH+1];
  logic [WIDTH-1:0] w_dc  [DEPTH+1];
  logic             w_rdy [DEPTH+1];
  logic [OW-1:0]    w_occ;
  assign w_vc[STG_IN]  = in_valid;
  assign w_dc[STG_IN]  = in_data;
  assign w_rdy[DEPTH]  = out_ready;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stg (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .i_up_valid (w_vc[g]),
      .i_up_data  (w_dc[g]),
      .i_rdy_dn   (w_rdy[g+1]),
      .o_rdy      (w_rdy[g]),
      .o_valid    (w_vc[g+1]),
      .o_data     (w_dc[g+1])
    );
  end
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) w_occ = w_occ + OW'(w_vc[k+1]);
  end
  // Flush blocks both ends so nothing transfers in the cycle that clears the stages.
  assign in_ready  = w_rdy[STG_IN] && !flush;
  assign out_valid = w_vc[DEPTH] && !flush;
  assign out_data  = w_dc[DEPTH];
  assign occupancy = w_occ;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed and randomized scoreboard bench for dff_pipe at DEPTH 4, 1 and 7.
module tb_dff_pipe;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;
  logic iv4 = 1'b0, or4 = 1'b1, ir4, ov4;
  logic iv1 = 1'b0, or1 = 1'b1, ir1, ov1;
  logic iv7 = 1'b0, or7 = 1'b1, ir7, ov7;
  logic [7:0] id4 = '0, id1 = '0, id7 = '0, od4, od1, od7;
  logic [2:0] oc4, oc7;
  logic [0:0] oc1;
  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .occupancy(oc4));
  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1));
  dff_pipe #(.WIDTH(8), .DEPTH(7), .RESET_VAL(8'h00)) u7 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv7), .in_ready(ir7), .in_data(id7),
    .out_valid(ov7), .out_ready(or7), .out_data(od7), .occupancy(oc7));
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q [3][$];
  int         m [3];
  logic       ps [3];
  logic [7:0] pd [3];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference: a FIFO of accepted items plus a push-minus-pop occupancy count.
  task automatic mon(input int i, input logic ivl, irl, ovl, orl, input logic [7:0] idl, odl,
                     input int occ);
    if (!rst) begin
      q[i].delete();
      m[i] = 0;
      ps[i] = 1'b0;
      chk($sformatf("rst_v[%0d]", i), 32'(ovl), 32'(0));
      return;
    end
    chk($sformatf("occ[%0d]", i), 32'(occ), 32'(m[i]));
    if (ps[i] && !flush) begin
      chk($sformatf("hold_v[%0d]", i), 32'(ovl), 32'(1));
      chk($sformatf("hold_d[%0d]", i), 32'(odl), 32'(pd[i]));
    end
    if (ovl && orl) begin
      if (q[i].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop[%0d]: got %0h expected nothing", i, odl);
      end else chk($sformatf("data[%0d]", i), 32'(odl), 32'(q[i].pop_front()));
    end
    if (ivl && irl) q[i].push_back(idl);
    m[i] = m[i] + int'(ivl && irl) - int'(ovl && orl);
    ps[i] = ovl && !orl;
    pd[i] = odl;
    if (flush) begin
      q[i].delete();
      m[i] = 0;
      ps[i] = 1'b0;
    end
  endtask
  always @(negedge clk) begin
    mon(0, iv4, ir4, ov4, or4, id4, od4, int'(oc4));
    mon(1, iv1, ir1, ov1, or1, id1, od1, int'(oc1));
    mon(2, iv7, ir7, ov7, or7, id7, od7, int'(oc7));
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  logic [7:0] tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int k;
  initial begin
    #2;
    chk("rst_ov", 32'(ov4), 32'(0));
    chk("rst_occ", 32'(oc4), 32'(0));
    chk("rst_ir", 32'(ir4), 32'(1));
`ifdef DFF_PIPE_DATA_RST_EN
    chk("rst_od", 32'(od4), 32'hA5);
`endif
    nxt();
    rst = 1'b1;
    for (int j = 0; j < 9; j++) begin
      iv4 = (j < 4);
      if (j < 4) id4 = tbl[j];
      @(negedge clk);
      chk("lat_v", 32'(ov4), 32'(j >= 4 && j < 8));
      if (j >= 4 && j < 8) chk("lat_d", 32'(od4), 32'(tbl[j-4]));
      nxt();
    end
    or4 = 1'b0;
    k = 0;
    for (int j = 0; j < 9; j++) begin
      iv4 = (j < 8);
      id4 = 8'hB0 + 8'(k);
      if (j == 7) or4 = 1'b1;
      @(negedge clk);
      if (j < 8) chk("stall_ir", 32'(ir4), 32'(j < 4 || j == 7));
      if (j >= 4) chk("stall_occ", 32'(oc4), 32'(4));
      if (j >= 4 && j < 8) chk("stall_od", 32'(od4), 32'hB0);
      if (ir4 && iv4) k++;
      nxt();
    end
    iv4 = 1'b0;
    repeat (6) nxt();
    or4 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      iv4 = (j < 2);
      id4 = 8'hC1 + 8'(j);
      nxt();
    end
    @(negedge clk);
    chk("pre_flush_v", 32'(ov4), 32'(1));
    nxt();
    flush = 1'b1;
    iv4 = 1'b1;
    id4 = 8'h77;
    @(negedge clk);
    chk("flush_ir", 32'(ir4), 32'(0));
    chk("flush_ov", 32'(ov4), 32'(0));
    nxt();
    flush = 1'b0;
    iv4 = 1'b0;
    @(negedge clk);
    chk("post_flush_occ", 32'(oc4), 32'(0));
    chk("post_flush_ov", 32'(ov4), 32'(0));
    nxt();
    or4 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      iv4 = 1'b1;
      id4 = 8'hD1 + 8'(j);
      nxt();
    end
    iv4 = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ov", 32'(ov4), 32'(0));
    chk("arst_occ", 32'(oc4), 32'(0));
    nxt();
    rst = 1'b1;
    chk("arst_ir", 32'(ir4), 32'(1));
    for (int j = 0; j < 5; j++) begin
      iv4 = (j == 0);
      id4 = 8'h5A;
      @(negedge clk);
      chk("rel_v", 32'(ov4), 32'(j == 4));
      if (j == 4) chk("rel_d", 32'(od4), 32'h5A);
      nxt();
    end
    for (int j = 0; j < 1000; j++) begin
      iv4 = 1'($urandom_range(0, 1));
      iv1 = 1'($urandom_range(0, 1));
      iv7 = 1'($urandom_range(0, 1));
      or4 = 1'($urandom_range(0, 1));
      or1 = 1'($urandom_range(0, 1));
      or7 = 1'($urandom_range(0, 1));
      id4 = 8'($urandom);
      id1 = 8'($urandom);
      id7 = 8'($urandom);
      nxt();
    end
    iv4 = 1'b0;
    iv1 = 1'b0;
    iv7 = 1'b0;
    or4 = 1'b1;
    or1 = 1'b1;
    or7 = 1'b1;
    repeat (12) nxt();
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("drain[%0d]", i), 32'(q[i].size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
